// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction/PC queue with valid/ready handshakes,
// branch flush, and a NOP bubble presented to decode when empty.
module fetch_decode_queue #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int DEPTH        = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    fetch_valid,
  output logic                    fetch_ready,
  input  logic [DATA_WIDTH-1:0]   instruction_fetch,
  input  logic [ADDRESS_BITS-1:0] inst_PC_fetch,
  input  logic                    decode_ready,
  output logic                    decode_valid,
  output logic [DATA_WIDTH-1:0]   instruction_decode,
  output logic [ADDRESS_BITS-1:0] inst_PC_decode,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL  = (PW+1)'(DEPTH);
  localparam logic [PW:0]   O_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] P_ONE = PW'(1);

  logic [DATA_WIDTH-1:0]   inst_mem [DEPTH];
  logic [ADDRESS_BITS-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic                    push;
  logic                    pop;

  assign fetch_ready  = (occupancy != FULL);
  assign decode_valid = (occupancy != '0);
  assign push = fetch_valid & fetch_ready & ~flush;
  assign pop  = decode_valid & decode_ready & ~flush;

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + O_ONE;
        2'b01:   occupancy <= occupancy - O_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= instruction_fetch;
      pc_mem[wr_ptr]   <= inst_PC_fetch;
    end
  end

  // Head presentation, NOP bubble when empty.
  always_comb begin
    instruction_decode = NOP_INST;
    inst_PC_decode     = '0;
    if (decode_valid) begin
      instruction_decode = inst_mem[rd_ptr];
      inst_PC_decode     = pc_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: DEPTH=2 instance for
// handshake/flush/reset cases, DEPTH=4 instance for streaming order.
module tb_fetch_decode_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] instruction_fetch;
  logic [19:0] inst_PC_fetch;
  logic        decode_ready;
  logic        decode_valid;
  logic [31:0] instruction_decode;
  logic [19:0] inst_PC_decode;
  logic [1:0]  occupancy;

  logic        flush4;
  logic        f4_valid;
  logic        f4_ready;
  logic [31:0] f4_inst;
  logic [19:0] f4_pc;
  logic        d4_ready;
  logic        d4_valid;
  logic [31:0] d4_inst;
  logic [19:0] d4_pc;
  logic [2:0]  occ4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  fetch_decode_queue #(.DEPTH(2)) u_dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .fetch_valid        (fetch_valid),
    .fetch_ready        (fetch_ready),
    .instruction_fetch  (instruction_fetch),
    .inst_PC_fetch      (inst_PC_fetch),
    .decode_ready       (decode_ready),
    .decode_valid       (decode_valid),
    .instruction_decode (instruction_decode),
    .inst_PC_decode     (inst_PC_decode),
    .occupancy          (occupancy)
  );

  fetch_decode_queue #(.DEPTH(4)) u_dut4 (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush4),
    .fetch_valid        (f4_valid),
    .fetch_ready        (f4_ready),
    .instruction_fetch  (f4_inst),
    .inst_PC_fetch      (f4_pc),
    .decode_ready       (d4_ready),
    .decode_valid       (d4_valid),
    .instruction_decode (d4_inst),
    .inst_PC_decode     (d4_pc),
    .occupancy          (occ4)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] i,
                      input logic [19:0] p);
    chk({tag, "_inst"}, 64'(instruction_decode), 64'(i));
    chk({tag, "_pc"}, 64'(inst_PC_decode), 64'(p));
  endtask

  logic [31:0] words [10];
  logic [31:0] q [$];
  int sent;
  int got;

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    fetch_valid = 1'b0;
    instruction_fetch = '0;
    inst_PC_fetch = '0;
    decode_ready = 1'b0;
    flush4 = 1'b0;
    f4_valid = 1'b0;
    f4_inst = '0;
    f4_pc = '0;
    d4_ready = 1'b0;
    #2;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_dv", 64'(decode_valid), 64'd0);
    chk("rst_fr", 64'(fetch_ready), 64'd1);
    head("rst", NOP, 20'h0);
    #1 reset = 1'b1;

    // Fill with decode stalled
    fetch_valid = 1'b1;
    instruction_fetch = 32'h00500093;
    inst_PC_fetch = 20'h00004;
    step();
    chk("a_occ", 64'(occupancy), 64'd1);
    chk("a_dv", 64'(decode_valid), 64'd1);
    head("a", 32'h00500093, 20'h00004);
    instruction_fetch = 32'h00A00113;
    inst_PC_fetch = 20'h00008;
    step();
    chk("full_occ", 64'(occupancy), 64'd2);
    chk("full_fr", 64'(fetch_ready), 64'd0);
    head("full", 32'h00500093, 20'h00004);
    instruction_fetch = 32'h00F00193;
    inst_PC_fetch = 20'h0000C;
    step();
    chk("ovf_occ", 64'(occupancy), 64'd2);
    head("ovf", 32'h00500093, 20'h00004);

    // Drain in order
    fetch_valid = 1'b0;
    decode_ready = 1'b1;
    step();
    chk("drb_occ", 64'(occupancy), 64'd1);
    head("drb", 32'h00A00113, 20'h00008);
    step();
    chk("dre_occ", 64'(occupancy), 64'd0);
    chk("dre_dv", 64'(decode_valid), 64'd0);
    head("dre", NOP, 20'h0);
    step();
    chk("udf_occ", 64'(occupancy), 64'd0);

    // Simultaneous push and pop at occupancy 1
    decode_ready = 1'b0;
    fetch_valid = 1'b1;
    instruction_fetch = 32'h10000000;
    inst_PC_fetch = 20'h00100;
    step();
    chk("d0_occ", 64'(occupancy), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      decode_ready = 1'b1;
      instruction_fetch = 32'h10000000 + 32'(i);
      inst_PC_fetch = 20'h00100 + 20'(4 * i);
      step();
      chk("pp_occ", 64'(occupancy), 64'd1);
      head("pp", 32'h10000000 + 32'(i), 20'h00100 + 20'(4 * i));
    end

    // Flush from full drops the offered word
    decode_ready = 1'b0;
    instruction_fetch = 32'h20000000;
    inst_PC_fetch = 20'h00200;
    step();
    chk("pf_occ", 64'(occupancy), 64'd2);
    flush = 1'b1;
    instruction_fetch = 32'h0EEEEEEE;
    inst_PC_fetch = 20'h00EEE;
    step();
    flush = 1'b0;
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_dv", 64'(decode_valid), 64'd0);
    chk("fl_fr", 64'(fetch_ready), 64'd1);
    head("fl", NOP, 20'h0);
    instruction_fetch = 32'h30000000;
    inst_PC_fetch = 20'h00300;
    step();
    chk("g_occ", 64'(occupancy), 64'd1);
    head("g", 32'h30000000, 20'h00300);
    instruction_fetch = 32'h30000004;
    inst_PC_fetch = 20'h00304;
    step();
    chk("h_occ", 64'(occupancy), 64'd2);

    // Asynchronous reset mid-cycle
    fetch_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_dv", 64'(decode_valid), 64'd0);
    chk("ar_fr", 64'(fetch_ready), 64'd1);
    head("ar", NOP, 20'h0);
    #1 reset = 1'b1;
    fetch_valid = 1'b1;
    instruction_fetch = 32'h40000000;
    inst_PC_fetch = 20'h00400;
    step();
    chk("j_occ", 64'(occupancy), 64'd1);
    head("j", 32'h40000000, 20'h00400);
    fetch_valid = 1'b0;

    // DEPTH=4 streaming with a directed stall pattern
    for (int i = 0; i < 10; i++)
      words[i] = 32'hA0000000 + 32'(i * 17);
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      f4_valid = (sent < 10);
      f4_inst = (sent < 10) ? words[sent] : '0;
      f4_pc = 20'(sent * 4);
      d4_ready = (cyc % 5 == 3) || (cyc >= 12);
      if (d4_valid && d4_ready) begin
        chk("s_inst", 64'(d4_inst), 64'(q[0]));
        void'(q.pop_front());
        got++;
      end
      if (f4_valid && f4_ready) begin
        q.push_back(words[sent]);
        sent++;
      end
      step();
      chk("s_occ", 64'(occ4), 64'(q.size()));
      chk("s_max", 64'(occ4 <= 3'd4), 64'd1);
    end
    f4_valid = 1'b0;
    d4_ready = 1'b0;
    chk("s_got", 64'(got), 64'd10);
    chk("s_end", 64'(occ4), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
